traffic_light_fsm: RTL and testbench



---
 rtl/traffic_light_pkg.sv | 24 ++
 rtl/traffic_light_if.sv | 11 +
 rtl/tick_dwell_counter.sv | 35 +++
 rtl/traffic_light_fsm.sv | 102 ++++++++++
 tb/tb_traffic_light_fsm.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_pkg.sv
// Shared lamp encodings, controller state type and counter sizing helper
// for the two-street traffic-light controller.
package traffic_light_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic [1:0] {
        GREEN_A  = 2'b00,
        YELLOW_A = 2'b01,
        GREEN_B  = 2'b10,
        YELLOW_B = 2'b11
    } state_e;

    // Dwell counter width; never below one bit so a 1-tick dwell still elaborates.
    function automatic int unsigned cnt_width(input int unsigned green_ticks,
                                              input int unsigned yellow_ticks);
        int unsigned m;
        m = (green_ticks > yellow_ticks) ? green_ticks : yellow_ticks;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/traffic_light_if.sv
// Tick/sensor inputs and lamp outputs of the traffic-light controller.
interface traffic_light_if;
    logic       tick;
    logic       car_b;
    logic [1:0] la;
    logic [1:0] lb;
    logic       cycle_done;

    modport master (output tick, car_b, input la, lb, cycle_done);
    modport slave  (input tick, car_b, output la, lb, cycle_done);
endinterface

// File: rtl/tick_dwell_counter.sv
// Tick-enabled dwell counter with clear, terminal compare and saturation.
module tick_dwell_counter #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [Width-1:0] last_i,
    output logic             last_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Clear wins over counting so a state change always starts a fresh dwell.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !last_o) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q >= last_i);

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-street traffic-light controller: main road A holds green until a side-street
// car is sensed, street B gets a fixed green slot. Lamps are Moore-decoded.
module traffic_light_fsm
    import traffic_light_pkg::*;
#(
    parameter int unsigned GREEN_TICKS  = 5,
    parameter int unsigned YELLOW_TICKS = 2
) (
    input logic            clk,
    input logic            reset,
    traffic_light_if.slave lamp_io
);

    localparam int unsigned CntW = cnt_width(GREEN_TICKS, YELLOW_TICKS);
    localparam logic [CntW-1:0] GreenLast  = CntW'(GREEN_TICKS - 1);
    localparam logic [CntW-1:0] YellowLast = CntW'(YELLOW_TICKS - 1);

    state_e          state_q, state_d;
    logic            clr;
    logic            last;
    logic [CntW-1:0] last_sel;
    logic            cycle_done_q, cycle_done_d;
    logic [1:0]      la, lb;

    tick_dwell_counter #(
        .Width (CntW)
    ) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .en_i   (lamp_io.tick),
        .clr_i  (clr),
        .last_i (last_sel),
        .last_o (last)
    );

    always_comb begin
        state_d      = state_q;
        clr          = 1'b0;
        cycle_done_d = 1'b0;
        last_sel     = GreenLast;
        case (state_q)
            GREEN_A: begin
                if (lamp_io.tick && last && lamp_io.car_b) begin
                    state_d = YELLOW_A;
                    clr     = 1'b1;
                end
            end
            YELLOW_A: begin
                last_sel = YellowLast;
                if (lamp_io.tick && last) begin
                    state_d = GREEN_B;
                    clr     = 1'b1;
                end
            end
            GREEN_B: begin
                if (lamp_io.tick && last) begin
                    state_d = YELLOW_B;
                    clr     = 1'b1;
                end
            end
            YELLOW_B: begin
                last_sel = YellowLast;
                if (lamp_io.tick && last) begin
                    state_d      = GREEN_A;
                    clr          = 1'b1;
                    cycle_done_d = 1'b1;
                end
            end
            default: begin
                state_d = GREEN_A;
                clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= GREEN_A;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    always_comb begin
        la = RED;
        lb = RED;
        case (state_q)
            GREEN_A:  la = GREEN;
            YELLOW_A: la = YELLOW;
            GREEN_B:  lb = GREEN;
            YELLOW_B: lb = YELLOW;
            default:  la = GREEN;
        endcase
    end

    assign lamp_io.la         = la;
    assign lamp_io.lb         = lb;
    assign lamp_io.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench: vector table, directed corner sequences and random
// stimulus against a tick-counting reference model, on two parameter sets.
module tb_traffic_light_fsm;
    import traffic_light_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    traffic_light_if bus0 ();
    traffic_light_if bus1 ();

    traffic_light_fsm #(.GREEN_TICKS(5), .YELLOW_TICKS(2)) dut0 (
        .clk     (clk),
        .reset   (reset),
        .lamp_io (bus0)
    );

    traffic_light_fsm #(.GREEN_TICKS(3), .YELLOW_TICKS(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .lamp_io (bus1)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0..3 = A green, A yellow, B green, B yellow;
    // m_k counts ticks seen in the current phase (unbounded).
    int   m_phase[2];
    int   m_k[2];
    bit   m_done[2];
    int   g_t[2] = '{5, 3};
    int   y_t[2] = '{2, 1};
    logic [1:0] la_tab[4] = '{2'b00, 2'b01, 2'b10, 2'b10};
    logic [1:0] lb_tab[4] = '{2'b10, 2'b10, 2'b00, 2'b01};

    function automatic void model_step(input bit r, input bit t, input bit c);
        bit adv;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_phase[i] = 0;
                m_k[i]     = 0;
                m_done[i]  = 1'b0;
            end else if (t) begin
                m_k[i] = m_k[i] + 1;
                if (m_phase[i] == 0)      adv = (m_k[i] >= g_t[i]) && c;
                else if (m_phase[i] == 2) adv = (m_k[i] == g_t[i]);
                else                      adv = (m_k[i] == y_t[i]);
                m_done[i] = adv && (m_phase[i] == 3);
                if (adv) begin
                    m_phase[i] = (m_phase[i] + 1) % 4;
                    m_k[i]     = 0;
                end
            end else begin
                m_done[i] = 1'b0;
            end
        end
    endfunction

    task automatic compare_model();
        logic [1:0] la, lb;
        logic       dn;
        for (int i = 0; i < 2; i++) begin
            la = (i == 0) ? bus0.la : bus1.la;
            lb = (i == 0) ? bus0.lb : bus1.lb;
            dn = (i == 0) ? bus0.cycle_done : bus1.cycle_done;
            checks++;
            if (la !== la_tab[m_phase[i]] || lb !== lb_tab[m_phase[i]] || dn !== m_done[i]) begin
                errors++;
                $display("FAIL model dut%0d t=%0t: la=%b lb=%b done=%b, required la=%b lb=%b done=%b",
                         i, $time, la, lb, dn, la_tab[m_phase[i]], lb_tab[m_phase[i]], m_done[i]);
            end
        end
    endtask

    task automatic drive(input bit r, input bit t, input bit c);
        reset      = r;
        bus0.tick  = t;
        bus1.tick  = t;
        bus0.car_b = c;
        bus1.car_b = c;
        @(posedge clk);
        model_step(r, t, c);
        #1;
        compare_model();
    endtask

    // Two idle clocks then a tick clock: tick every 3 clk.
    task automatic tick_period(input bit r, input bit c);
        drive(r, 1'b0, c);
        drive(r, 1'b0, c);
        drive(r, 1'b1, c);
    endtask

    task automatic check_exp(input string name, input logic [1:0] la, input logic [1:0] lb,
                             input logic dn);
        checks++;
        if (bus0.la !== la || bus0.lb !== lb || bus0.cycle_done !== dn) begin
            errors++;
            $display("FAIL %s: la=%b lb=%b done=%b, required la=%b lb=%b done=%b",
                     name, bus0.la, bus0.lb, bus0.cycle_done, la, lb, dn);
        end
    endtask

    typedef struct {
        bit         rst;
        bit         car;
        int         ticks;
        logic [1:0] la;
        logic [1:0] lb;
        bit         done;
    } vec_t;

    vec_t vecs[11];

    initial begin
        bus0.tick = 1'b0; bus1.tick = 1'b0;
        bus0.car_b = 1'b0; bus1.car_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_k[i] = 0; m_done[i] = 1'b0;
        end

        // Full A->B->A cycle with car_b high, then a long quiet main-road green.
        vecs[0]  = '{1'b1, 1'b1, 3,  2'b00, 2'b10, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4,  2'b00, 2'b10, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1,  2'b01, 2'b10, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1,  2'b01, 2'b10, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1,  2'b10, 2'b00, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4,  2'b10, 2'b00, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1,  2'b10, 2'b01, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1,  2'b10, 2'b01, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1,  2'b00, 2'b10, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 20, 2'b00, 2'b10, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1,  2'b01, 2'b10, 1'b0};

        drive(1'b1, 1'b1, 1'b0);
        for (int v = 0; v < 11; v++) begin
            for (int k = 0; k < vecs[v].ticks; k++) tick_period(vecs[v].rst, vecs[v].car);
            check_exp($sformatf("vec%0d", v), vecs[v].la, vecs[v].lb, vecs[v].done);
        end
        drive(1'b0, 1'b0, 1'b0);
        check_exp("done_one_clk_only", 2'b01, 2'b10, 1'b0);

        // car_b pulses only between ticks are lost; a tick-sampled car_b acts at once.
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) tick_period(1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        check_exp("pulse_between_ticks", 2'b00, 2'b10, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        check_exp("car_on_saturated_tick", 2'b01, 2'b10, 1'b0);

        // Freeze in GREEN_B with tick low, then three more ticks to YELLOW_B.
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) tick_period(1'b0, 1'b1);
        check_exp("enter_green_b", 2'b10, 2'b00, 1'b0);
        for (int k = 0; k < 2; k++) tick_period(1'b0, 1'b0);
        for (int k = 0; k < 30; k++) drive(1'b0, 1'b0, 1'b1);
        check_exp("frozen_green_b", 2'b10, 2'b00, 1'b0);
        for (int k = 0; k < 2; k++) tick_period(1'b0, 1'b0);
        check_exp("green_b_two_more", 2'b10, 2'b00, 1'b0);
        tick_period(1'b0, 1'b0);
        check_exp("yellow_b_after_three", 2'b10, 2'b01, 1'b0);

        // Reset coincident with the deciding tick in YELLOW_B.
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) tick_period(1'b0, 1'b1);
        check_exp("in_yellow_b", 2'b10, 2'b01, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        check_exp("reset_beats_tick", 2'b00, 2'b10, 1'b0);

        // Random ticks, sensor levels and occasional resets.
        drive(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
